// File: rtl/split_slave_port.sv
// split_slave_port: slave-side endpoint of the serial system bus for a
// split-capable slave.
//
// It deserialises an address (and write data) LSB first and runs a
// variable-latency memory access. If the memory stalls for SPLIT_THRESH
// cycles, the port raises ssplit. It drops ssplit when the memory
// completes, and finishes the transaction only after the arbiter's
// split_grant pulse.
//
// Build option: define SPLIT_SLAVE_SPLIT_EN to compile the split logic.
// Without it, ssplit is tied 0, split_grant is ignored, and the memory
// phase waits for mem_ack indefinitely.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   sel, svalid       decoder select, serial data qualifier
//   swdata, smode     serial addr/wdata, write(1)/read(0) on first bit
//   split_grant       arbiter pulse resuming a split transaction
//   sready, ssplit    idle indicator, split in progress
//   srdata, srvalid   serial read data and qualifier
//   mem_req/we/addr/wdata, mem_ack, mem_rdata   memory side
module split_slave_port #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int SPLIT_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel,
    input  logic                  svalid,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  split_grant,
    output logic                  sready,
    output logic                  ssplit,
    output logic                  srdata,
    output logic                  srvalid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int BW   = $clog2(MAXW + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_WDATA  = 3'd2,
        S_MEM    = 3'd3,
        S_RDATA  = 3'd6
`ifdef SPLIT_SLAVE_SPLIT_EN
        ,
        S_SPLIT  = 3'd4,
        S_RESUME = 3'd5
`endif
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [BW-1:0]         r_bit;
    logic                  r_mode;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rsh;
    logic                  r_sready;
    logic                  r_srdata;
    logic                  r_srvalid;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic                  w_take;
    logic                  w_addr_last;
    logic                  w_data_last;
    logic                  w_rd_done;
    logic                  w_req_nxt;

    assign w_take      = sel && svalid;
    assign w_addr_last = (r_bit == BW'(ADDR_WIDTH - 1));
    assign w_data_last = (r_bit == BW'(DATA_WIDTH - 1));
    assign w_rd_done   = (r_bit == BW'(DATA_WIDTH));

`ifdef SPLIT_SLAVE_SPLIT_EN
    localparam int WW = $clog2(SPLIT_THRESH + 1);

    logic [WW-1:0] r_wait;
    logic          r_ssplit;
    logic          w_wait_hit;

    // The current cycle is the SPLIT_THRESH-th cycle without an ack.
    assign w_wait_hit = (r_wait == WW'(SPLIT_THRESH - 1));
    assign ssplit     = r_ssplit;
    assign w_req_nxt  = (w_next == S_MEM) || (w_next == S_SPLIT);
`else
    logic w_unused;

    assign w_unused  = split_grant;
    assign ssplit    = 1'b0;
    assign w_req_nxt = (w_next == S_MEM);
`endif

    assign sready    = r_sready;
    assign srdata    = r_srdata;
    assign srvalid   = r_srvalid;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (!sel) begin
                    w_next = S_IDLE;
                end else if (svalid && w_addr_last) begin
                    w_next = r_mode ? S_WDATA : S_MEM;
                end
            end
            S_WDATA: begin
                if (!sel) begin
                    w_next = S_IDLE;
                end else if (svalid && w_data_last) begin
                    w_next = S_MEM;
                end
            end
            S_MEM: begin
                // An ack in the threshold cycle wins over the split.
                if (mem_ack) begin
                    w_next = r_mode ? S_IDLE : S_RDATA;
                end
`ifdef SPLIT_SLAVE_SPLIT_EN
                else if (w_wait_hit) begin
                    w_next = S_SPLIT;
                end
`endif
            end
`ifdef SPLIT_SLAVE_SPLIT_EN
            S_SPLIT: begin
                if (mem_ack) begin
                    w_next = S_RESUME;
                end
            end
            S_RESUME: begin
                if (split_grant) begin
                    w_next = r_mode ? S_IDLE : S_RDATA;
                end
            end
`endif
            S_RDATA: begin
                if (w_rd_done) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output flags are registered from the next state, so each one
    // changes in the cycle after the event that causes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit     <= '0;
            r_mode    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rsh     <= '0;
            r_sready  <= 1'b1;
            r_srdata  <= 1'b0;
            r_srvalid <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
        end else begin
            r_sready  <= (w_next == S_IDLE);
            r_srvalid <= (w_next == S_RDATA);
            r_mem_req <= w_req_nxt;
            r_mem_we  <= w_req_nxt && r_mode;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_mode <= smode;
                        r_addr <= {swdata, r_addr[ADDR_WIDTH-1:1]};
                        r_bit  <= BW'(1);
                    end
                end
                S_ADDR: begin
                    if (w_take) begin
                        r_addr <= {swdata, r_addr[ADDR_WIDTH-1:1]};
                        r_bit  <= w_addr_last ? '0 : r_bit + BW'(1);
                    end
                end
                S_WDATA: begin
                    if (w_take) begin
                        r_wdata <= {swdata, r_wdata[DATA_WIDTH-1:1]};
                        r_bit   <= r_bit + BW'(1);
                    end
                end
                S_MEM: begin
                    if (mem_ack && !r_mode) begin
                        r_srdata <= mem_rdata[0];
                        r_rsh    <= mem_rdata >> 1;
                        r_bit    <= BW'(1);
                    end
                end
`ifdef SPLIT_SLAVE_SPLIT_EN
                S_SPLIT: begin
                    if (mem_ack) begin
                        r_rsh <= mem_rdata;
                    end
                end
                S_RESUME: begin
                    if (split_grant && !r_mode) begin
                        r_srdata <= r_rsh[0];
                        r_rsh    <= r_rsh >> 1;
                        r_bit    <= BW'(1);
                    end
                end
`endif
                S_RDATA: begin
                    // r_bit counts bits already on srdata.
                    if (w_rd_done) begin
                        r_srdata <= 1'b0;
                    end else begin
                        r_srdata <= r_rsh[0];
                        r_rsh    <= r_rsh >> 1;
                        r_bit    <= r_bit + BW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SPLIT_SLAVE_SPLIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait   <= '0;
            r_ssplit <= 1'b0;
        end else begin
            r_ssplit <= (w_next == S_SPLIT);
            if (r_state == S_MEM && !mem_ack) begin
                r_wait <= r_wait + WW'(1);
            end else begin
                r_wait <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_split_slave_port.sv
// tb_split_slave_port: table-driven transactions with a scoreboard for
// memory requests and serial read bytes, plus hand-written corner cases.
module tb_split_slave_port;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TH = 4;

`ifdef SPLIT_SLAVE_SPLIT_EN
    localparam bit SPLIT_ON = 1'b1;
`else
    localparam bit SPLIT_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          sel;
    logic          svalid;
    logic          swdata;
    logic          smode;
    logic          split_grant;
    logic          sready;
    logic          ssplit;
    logic          srdata;
    logic          srvalid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    split_slave_port #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .SPLIT_THRESH(TH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .svalid     (svalid),
        .swdata     (swdata),
        .smode      (smode),
        .split_grant(split_grant),
        .sready     (sready),
        .ssplit     (ssplit),
        .srdata     (srdata),
        .srvalid    (srvalid),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        int            ack_cyc;
        int            grant_dly;
        int            gap;
        bit            exp_split;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        bit            wr;
    } mexp_t;

    int            n_cmp = 0;
    int            n_err = 0;
    mexp_t         q_mem[$];
    logic [DW-1:0] q_rd[$];
    vec_t          vecs[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Memory request scoreboard: one entry per rising mem_req.
    logic  prev_req = 1'b0;
    mexp_t m_cur;
    always @(negedge clk) begin
        if (mem_req && !prev_req) begin
            if (q_mem.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL req_unexpected: got mem_req=1 expected 0");
            end else begin
                m_cur = q_mem.pop_front();
                check("mem_addr", 32'(mem_addr), 32'(m_cur.addr));
                check("mem_we", 32'(mem_we), 32'(m_cur.wr));
                if (m_cur.wr) begin
                    check("mem_wdata", 32'(mem_wdata), 32'(m_cur.wd));
                end
            end
        end
        prev_req = mem_req;
    end

    // Read data scoreboard: DW consecutive srvalid bits form one byte.
    logic [DW-1:0] rd_sh = '0;
    int            rd_n  = 0;
    logic [DW-1:0] rd_exp;
    always @(negedge clk) begin
        if (srvalid) begin
            rd_sh = {srdata, rd_sh[DW-1:1]};
            rd_n++;
            if (rd_n == DW) begin
                rd_n = 0;
                if (q_rd.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_unexpected: got byte %0h expected none",
                             rd_sh);
                end else begin
                    rd_exp = q_rd.pop_front();
                    check("rd_byte", 32'(rd_sh), 32'(rd_exp));
                end
            end
        end else if (rd_n != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rd_gap: got %0d bits expected %0d", rd_n, DW);
            rd_n = 0;
        end
    end

    task automatic send(input vec_t v);
        for (int i = 0; i < AW; i++) begin
            if (i == v.gap) begin
                repeat (2) begin
                    @(negedge clk);
                    sel    = 1'b1;
                    svalid = 1'b0;
                    swdata = 1'($urandom);
                end
            end
            @(negedge clk);
            if (i == 1) check("sready_fall", 32'(sready), 32'd0);
            sel    = 1'b1;
            svalid = 1'b1;
            swdata = v.addr[i];
            smode  = (i == 0) ? v.wr : 1'($urandom);
        end
        if (v.wr) begin
            for (int j = 0; j < DW; j++) begin
                @(negedge clk);
                swdata = v.wd[j];
                smode  = 1'($urandom);
            end
        end
        @(negedge clk);
        sel    = 1'b0;
        svalid = 1'b0;
    endtask

    task automatic wait_rd_done();
        int t;
        t = 0;
        while (q_rd.size() != 0 && t < 30) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("rd_timeout", 32'(t < 30), 32'd1);
        @(negedge clk);
        check("sready_after_rd", 32'(sready), 32'd1);
    endtask

    task automatic run(input vec_t v);
        mexp_t m;
        bit    seen;
        int    k;
        m.addr = v.addr;
        m.wd   = v.wd;
        m.wr   = v.wr;
        q_mem.push_back(m);
        if (!v.wr) q_rd.push_back(v.rd);
        send(v);
        check("req_rise", 32'(mem_req), 32'd1);
        seen = 1'b0;
        k    = 1;
        while (k <= 40) begin
            if (ssplit) seen = 1'b1;
            if (k == TH) check("ssplit_at_thresh", 32'(ssplit), 32'd0);
            if (k == TH + 1) check("ssplit_rise", 32'(ssplit), 32'(v.exp_split));
            if (k == v.ack_cyc) begin
                mem_ack   = 1'b1;
                mem_rdata = v.rd;
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                break;
            end
            mem_rdata = 8'($urandom);
            @(negedge clk);
            k++;
        end
        check("req_fall", 32'(mem_req), 32'd0);
        check("ssplit_fall", 32'(ssplit), 32'd0);
        check("split_seen", 32'(seen), 32'(v.exp_split));
        if (v.exp_split) begin
            check("sready_resume", 32'(sready), 32'd0);
            repeat (v.grant_dly) begin
                @(negedge clk);
                check("no_rd_before_grant", 32'(srvalid), 32'd0);
            end
            split_grant = 1'b1;
            @(negedge clk);
            split_grant = 1'b0;
        end
        if (v.wr) begin
            check("sready_after_wr", 32'(sready), 32'd1);
        end else begin
            check("rd_first", 32'(srvalid), 32'd1);
            wait_rd_done();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int       bad;
        logic [AW-1:0] ra;
        rst         = 1'b1;
        sel         = 1'b0;
        svalid      = 1'b0;
        swdata      = 1'b0;
        smode       = 1'b0;
        split_grant = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;

        vecs[0] = '{wr: 1'b1, addr: 12'h0A5, wd: 8'h3C, rd: 8'h00,
                    ack_cyc: 2, grant_dly: 0, gap: -1, exp_split: 1'b0};
        vecs[1] = '{wr: 1'b0, addr: 12'hFFF, wd: 8'h00, rd: 8'h96,
                    ack_cyc: 1, grant_dly: 0, gap: -1, exp_split: 1'b0};
        vecs[2] = '{wr: 1'b0, addr: 12'h123, wd: 8'h00, rd: 8'h5A,
                    ack_cyc: 10, grant_dly: 3, gap: -1, exp_split: SPLIT_ON};
        vecs[3] = '{wr: 1'b0, addr: 12'h456, wd: 8'h00, rd: 8'hC3,
                    ack_cyc: 4, grant_dly: 0, gap: -1, exp_split: 1'b0};
        vecs[4] = '{wr: 1'b1, addr: 12'h7E1, wd: 8'hA5, rd: 8'h00,
                    ack_cyc: 7, grant_dly: 2, gap: 3, exp_split: SPLIT_ON};
        vecs[5] = '{wr: 1'b0, addr: 12'h800, wd: 8'h00, rd: 8'h81,
                    ack_cyc: 5, grant_dly: 0, gap: 7, exp_split: SPLIT_ON};

        repeat (2) @(negedge clk);
        check("rst_sready", 32'(sready), 32'd1);
        check("rst_ssplit", 32'(ssplit), 32'd0);
        check("rst_srdata", 32'(srdata), 32'd0);
        check("rst_srvalid", 32'(srvalid), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 6; n++) begin
            run(vecs[n]);
        end

        // Abort: sel dropped after five address bits.
        ra = 12'h5C3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sel    = 1'b1;
            svalid = 1'b1;
            swdata = ra[i];
            smode  = 1'b0;
        end
        @(negedge clk);
        sel    = 1'b0;
        svalid = 1'b0;
        @(negedge clk);
        check("abort_sready", 32'(sready), 32'd1);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_req) bad++;
        end
        check("abort_no_req", 32'(bad), 32'd0);

        // Reset while the read is stalled (in SPLIT when split is built).
        run(vecs[3]);
        q_mem.push_back('{addr: 12'h3A7, wd: 8'h00, wr: 1'b0});
        send('{wr: 1'b0, addr: 12'h3A7, wd: 8'h00, rd: 8'h00,
               ack_cyc: 0, grant_dly: 0, gap: -1, exp_split: 1'b0});
        repeat (6) @(negedge clk);
        check("stall_ssplit", 32'(ssplit), 32'(SPLIT_ON));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ssplit", 32'(ssplit), 32'd0);
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_sready", 32'(sready), 32'd1);
        split_grant = 1'b1;
        @(negedge clk);
        split_grant = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stray_grant_sready", 32'(sready), 32'd1);
            check("stray_grant_srvalid", 32'(srvalid), 32'd0);
            check("stray_grant_req", 32'(mem_req), 32'd0);
        end

        // A normal read still works after the mid-transaction reset.
        run(vecs[1]);

        check("q_mem_empty", 32'(q_mem.size()), 32'd0);
        check("q_rd_empty", 32'(q_rd.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/split_slave_port.md
# split_slave_port

Slave-side endpoint of the serial system bus for the split-capable slave. It deserialises address and write data from the granted master and runs a variable-latency memory access. When that access stalls past a threshold, it issues a split to the arbiter, releases the split once the memory completes, and finishes the transaction (read data serialised back) only after the arbiter's `split_grant` pulse. Its `sready` and `ssplit` drive the arbiter's `sreadysp` and `ssplit` inputs.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: serial address bits per transaction.
- `DATA_WIDTH`, 8: data bits per transaction.
- `SPLIT_THRESH`, 4: memory-wait cycles before a split is issued; must be at least 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  bus clock; all logic on its rising edge.
- `rst`  in  1  synchronous active-high reset.
- `sel`  in  1  address decoder has selected this slave.
- `svalid`  in  1  qualifies `swdata` this cycle.
- `swdata`  in  1  serial address/write data, LSB first.
- `smode`  in  1  1 = write, 0 = read; sampled with the first address bit.
- `split_grant`  in  1  arbiter pulse allowing the split owner to continue.
- `sready`  out  1  slave idle and able to accept a transaction.
- `ssplit`  out  1  split in progress.
- `srdata`  out  1  serial read data, LSB first.
- `srvalid`  out  1  qualifies `srdata`.
- `mem_req`  out  1  memory request, held until ack.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  `ADDR_WIDTH`  memory address.
- `mem_wdata`  out  `DATA_WIDTH`  memory write data.
- `mem_ack`  in  1  one-cycle completion pulse from memory.
- `mem_rdata`  in  `DATA_WIDTH`  read data, valid with `mem_ack`.

## Operation
- States: IDLE, ADDR, WDATA, MEM, SPLIT, RESUME, RDATA.
- **IDLE**
  - `sready`=1.
  - `sel && svalid` captures bit 0 of the address and latches `smode` → ADDR.
- **ADDR / WDATA**
  - Shift one bit per cycle with `svalid`=1. Gaps with `svalid`=0 hold state.
  - `sel`=0 in either state aborts to IDLE. No memory access occurs.
  - After `ADDR_WIDTH` address bits: write → WDATA; read → MEM.
  - After `DATA_WIDTH` data bits → MEM.
- **MEM**
  - `mem_req`=1, with `mem_we`, `mem_addr` and `mem_wdata` stable.
  - A wait counter (width `$clog2(SPLIT_THRESH+1)`) increments each cycle without `mem_ack`.
  - `mem_ack` → read: RDATA, with `mem_rdata` latched; write: IDLE.
  - Counter reaching `SPLIT_THRESH` without ack → SPLIT.
  - `mem_ack` in the threshold cycle takes priority: no split.
- **SPLIT**
  - `ssplit`=1 and `mem_req` stays high.
  - `mem_ack` → latch data, `ssplit`=0 → RESUME.
- **RESUME**
  - Waits for `split_grant` → read: RDATA; write: IDLE.
  - `split_grant` in any other state is ignored.
- **RDATA**
  - Shifts `DATA_WIDTH` bits out on `srdata` with `srvalid`=1, LSB first, back-to-back → IDLE.
- `sel`, `svalid` and `swdata` are ignored in MEM, SPLIT, RESUME and RDATA.
- `sready`=0 in every state except IDLE.

## Timing
- All outputs are registered.
- Reset values: `sready`=1; `ssplit`, `srdata`, `srvalid`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata` = 0.
- `sready` falls the cycle after the first address bit is sampled.
- `mem_req` rises the cycle after the final serial bit is sampled.
- `mem_req` falls the cycle after `mem_ack`.
- `ssplit` rises the cycle after the `SPLIT_THRESH`-th unacknowledged `mem_req` cycle.
- `ssplit` falls the cycle after `mem_ack`.
- First `srdata` bit appears the cycle after `mem_ack` (no split) or after `split_grant` (split).
- `sready` rises the cycle after the last `srdata` bit, the write `mem_ack`, or the write `split_grant`.
- Reset in any state: IDLE and reset values on the next cycle; an in-flight `mem_req` is dropped.

## Configuration
- `SPLIT_SLAVE_SPLIT_EN` defined: split behaviour as above.
- Not defined:
  - SPLIT and RESUME and the wait counter are not compiled.
  - `ssplit` is tied 0 and `split_grant` is ignored.
  - MEM waits indefinitely for `mem_ack`.

## Test plan
Defaults apply: ADDR 12, DATA 8, THRESH 4.
- Write to 0x0A5 with data 0x3C, `mem_ack` on the 2nd `mem_req` cycle → `mem_addr`=0x0A5, `mem_wdata`=0x3C, `mem_we`=1; `ssplit` never rises; `sready`=1 one cycle after ack.
- Read from 0xFFF, `mem_rdata`=0x96 acked on the 1st cycle → `srdata` = 0,1,1,0,1,0,0,1 over 8 consecutive `srvalid` cycles.
- Read with ack on the 10th `mem_req` cycle and data 0x5A → `ssplit` high after 4 cycles and low the cycle after ack. No `srvalid` appears until a `split_grant` pulse injected 3 cycles later; then 0x5A is shifted out.
- `mem_ack` on exactly the 4th `mem_req` cycle → `ssplit` stays 0 and read proceeds.
- `sel` dropped after 5 address bits → IDLE, `mem_req` never asserted, `sready`=1 the next cycle.
- `rst` asserted in SPLIT → next cycle `ssplit`=0, `mem_req`=0, `sready`=1. A stray `split_grant` afterwards causes no output change.
